spi_peripheral_responder: RTL

SPI peripheral (target) end of the controller link: a register-file responder driven by an SPI controller over spi_clk/cs_b/pico, returning data on poci. It is used as an on-fabric loopback target and as a chip-side model for bench and in-system checks of the SPI controller interface. SPI mode 0 only: pico is sampled on the rising spi_clk edge and poci changes on the falling edge. All SPI inputs are oversampled in the S_AXI_ACLK domain.

---
 rtl/spi_periph_pkg.sv | 27 ++
 rtl/spi_periph_sync.sv | 52 +++++
 rtl/spi_peripheral_responder.sv | 267 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_periph_pkg.sv
// Shared constants, FSM state type and address helper for the SPI peripheral
// responder. Optional build macro: SPI_PERIPH_AUTOINC_EN (auto-increment bursts).
package spi_periph_pkg;

  // Command byte layout: bit7 = R/W (1 = read), bits6:0 = register address
  localparam int CMD_WIDTH    = 8;
  localparam int CMD_RW_BIT   = 7;
  localparam int CMD_ADDR_MSB = 6;
  localparam int ADDR_WIDTH   = 7;

  typedef enum logic [1:0] {
    IDLE,
    CMD,
    DATA,
    IGNORE
  } state_t;

  // Next register address in a burst, wrapping from the last register to 0
  function automatic logic [ADDR_WIDTH-1:0] next_addr(input logic [ADDR_WIDTH-1:0] addr,
                                                      input int num_regs);
    if (int'(addr) >= num_regs - 1) begin
      return '0;
    end
    return addr + ADDR_WIDTH'(1);
  endfunction

endpackage

// File: rtl/spi_periph_sync.sv
// Oversampling front end for the SPI pins: SYNC_STAGES-deep synchronizers on
// spi_clk, cs_b and pico, plus edge detection from the last two synchronized
// samples. cs_b is carried inverted so every flop resets to 0 and the link
// reads as "not selected" straight out of reset.
module spi_periph_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic spi_clk,
  input  logic cs_b,
  input  logic pico,
  output logic sclk_rise,
  output logic sclk_fall,
  output logic cs_active,
  output logic cs_start,
  output logic pico_s
);

  logic [SYNC_STAGES-1:0] sclk_sync_reg;
  logic [SYNC_STAGES-1:0] act_sync_reg;
  logic [SYNC_STAGES-1:0] pico_sync_reg;
  logic                   sclk_prev_reg;
  logic                   act_prev_reg;

  // Shift the raw pins through the synchronizer chains and keep one extra
  // sample of spi_clk and chip-select activity for edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_sync_reg <= '0;
      act_sync_reg  <= '0;
      pico_sync_reg <= '0;
      sclk_prev_reg <= 1'b0;
      act_prev_reg  <= 1'b0;
    end else begin
      sclk_sync_reg <= {sclk_sync_reg[SYNC_STAGES-2:0], spi_clk};
      act_sync_reg  <= {act_sync_reg[SYNC_STAGES-2:0], ~cs_b};
      pico_sync_reg <= {pico_sync_reg[SYNC_STAGES-2:0], pico};
      sclk_prev_reg <= sclk_sync_reg[SYNC_STAGES-1];
      act_prev_reg  <= act_sync_reg[SYNC_STAGES-1];
    end
  end

  // pico goes through the same depth as spi_clk, so pico_s is the bit that
  // was on the wire when the detected rising edge happened
  assign sclk_rise = sclk_sync_reg[SYNC_STAGES-1] & ~sclk_prev_reg;
  assign sclk_fall = ~sclk_sync_reg[SYNC_STAGES-1] & sclk_prev_reg;
  assign cs_active = act_sync_reg[SYNC_STAGES-1];
  assign cs_start  = act_sync_reg[SYNC_STAGES-1] & ~act_prev_reg;
  assign pico_s    = pico_sync_reg[SYNC_STAGES-1];

endmodule

// File: rtl/spi_peripheral_responder.sv
// SPI mode-0 peripheral register file: 8-bit command (R/W + address) followed
// by DATA_WIDTH data bits, MSB first, with a fabric-side host port.
// Optional build macro: SPI_PERIPH_AUTOINC_EN -- when defined, the address
// auto-increments after each word and the frame continues as a burst.
module spi_peripheral_responder
  import spi_periph_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int NUM_REGS    = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  S_AXI_ACLK,
  input  logic                  S_AXI_ARESETN,
  input  logic                  spi_clk,
  input  logic                  cs_b,
  input  logic                  pico,
  output logic                  poci,
  input  logic                  host_we,
  input  logic [ADDR_WIDTH-1:0] host_waddr,
  input  logic [DATA_WIDTH-1:0] host_wdata,
  input  logic [ADDR_WIDTH-1:0] host_raddr,
  output logic [DATA_WIDTH-1:0] host_rdata,
  output logic                  frame_done,
  output logic                  frame_error,
  output logic                  addr_error,
  output logic                  busy
);

  localparam int CNT_W = $clog2(DATA_WIDTH > CMD_WIDTH ? DATA_WIDTH : CMD_WIDTH);
  localparam int IDX_W = $clog2(NUM_REGS);

  logic sclk_rise;
  logic sclk_fall;
  logic cs_active;
  logic cs_start;
  logic pico_s;

  spi_periph_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk      (S_AXI_ACLK),
    .rst_n    (S_AXI_ARESETN),
    .spi_clk  (spi_clk),
    .cs_b     (cs_b),
    .pico     (pico),
    .sclk_rise(sclk_rise),
    .sclk_fall(sclk_fall),
    .cs_active(cs_active),
    .cs_start (cs_start),
    .pico_s   (pico_s)
  );

  logic [DATA_WIDTH-1:0] regs [NUM_REGS];

  // Out-of-range addresses read as zero instead of aliasing onto a register
  function automatic logic [DATA_WIDTH-1:0] reg_read(input logic [ADDR_WIDTH-1:0] addr);
    if (int'(addr) < NUM_REGS) begin
      return regs[addr[IDX_W-1:0]];
    end
    return '0;
  endfunction

  state_t                  state_reg;
  logic [CNT_W-1:0]        bit_cnt_reg;
  logic [CMD_WIDTH-2:0]    cmd_shift_reg;
  logic [DATA_WIDTH-1:0]   rx_reg;
  logic [DATA_WIDTH-1:0]   tx_reg;
  logic                    rw_reg;
  logic [ADDR_WIDTH-1:0]   addr_reg;
  logic                    data_seen_reg;
  logic                    boundary_reg;
  logic                    poci_reg;
  logic                    frame_done_reg;
  logic                    frame_error_reg;
  logic                    addr_error_reg;
  logic                    spi_we_reg;
  logic [ADDR_WIDTH-1:0]   spi_waddr_reg;
  logic [DATA_WIDTH-1:0]   spi_wdata_reg;
  logic [DATA_WIDTH-1:0]   host_rdata_reg;

  logic [CMD_WIDTH-1:0]    cmd_full;
  logic [ADDR_WIDTH-1:0]   cmd_addr;
  logic                    cmd_addr_ok;
  logic [DATA_WIDTH-1:0]   cmd_rd_word;
  logic [DATA_WIDTH-1:0]   rx_full;
  logic                    word_last;
`ifdef SPI_PERIPH_AUTOINC_EN
  logic [ADDR_WIDTH-1:0]   addr_next;
  logic [DATA_WIDTH-1:0]   next_rd_word;
`endif

  // Values as they will be once the bit currently on pico is shifted in
  always_comb begin
    cmd_full    = {cmd_shift_reg, pico_s};
    cmd_addr    = cmd_full[CMD_ADDR_MSB:0];
    cmd_addr_ok = (int'(cmd_addr) < NUM_REGS);
    cmd_rd_word = reg_read(cmd_addr);
    rx_full     = {rx_reg[DATA_WIDTH-2:0], pico_s};
    word_last   = (bit_cnt_reg == CNT_W'(DATA_WIDTH - 1));
`ifdef SPI_PERIPH_AUTOINC_EN
    addr_next    = next_addr(addr_reg, NUM_REGS);
    next_rd_word = reg_read(addr_next);
`endif
  end

  // Frame FSM: command capture, data shifting, word completion and error pulses
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      state_reg       <= IDLE;
      bit_cnt_reg     <= '0;
      cmd_shift_reg   <= '0;
      rx_reg          <= '0;
      tx_reg          <= '0;
      rw_reg          <= 1'b0;
      addr_reg        <= '0;
      data_seen_reg   <= 1'b0;
      boundary_reg    <= 1'b0;
      poci_reg        <= 1'b0;
      frame_done_reg  <= 1'b0;
      frame_error_reg <= 1'b0;
      addr_error_reg  <= 1'b0;
      spi_we_reg      <= 1'b0;
      spi_waddr_reg   <= '0;
      spi_wdata_reg   <= '0;
    end else begin
      frame_done_reg  <= 1'b0;
      frame_error_reg <= 1'b0;
      addr_error_reg  <= 1'b0;
      spi_we_reg      <= 1'b0;
      if (!cs_active) begin
        // Deselect mid-command (after any bit) or mid-word is an abort;
        // a clean word boundary in a burst is a normal end of frame
        if ((state_reg == CMD && bit_cnt_reg != '0) ||
            (state_reg == DATA && !boundary_reg)) begin
          frame_error_reg <= 1'b1;
        end
        state_reg     <= IDLE;
        bit_cnt_reg   <= '0;
        data_seen_reg <= 1'b0;
        boundary_reg  <= 1'b0;
        poci_reg      <= 1'b0;
      end else begin
        case (state_reg)
          IDLE: begin
            if (cs_start) begin
              state_reg   <= CMD;
              bit_cnt_reg <= '0;
            end
          end
          CMD: begin
            if (sclk_rise) begin
              cmd_shift_reg <= cmd_full[CMD_WIDTH-2:0];
              if (bit_cnt_reg == CNT_W'(CMD_WIDTH - 1)) begin
                bit_cnt_reg   <= '0;
                rw_reg        <= cmd_full[CMD_RW_BIT];
                addr_reg      <= cmd_addr;
                data_seen_reg <= 1'b0;
                boundary_reg  <= 1'b0;
                if (!cmd_addr_ok) begin
                  addr_error_reg <= 1'b1;
                  state_reg      <= IGNORE;
                  poci_reg       <= 1'b0;
                end else begin
                  state_reg <= DATA;
                  // Snapshot the register now so later host writes cannot
                  // disturb the word already committed to the wire
                  if (cmd_full[CMD_RW_BIT]) begin
                    tx_reg   <= cmd_rd_word;
                    poci_reg <= cmd_rd_word[DATA_WIDTH-1];
                  end
                end
              end else begin
                bit_cnt_reg <= bit_cnt_reg + CNT_W'(1);
              end
            end
          end
          DATA: begin
            if (sclk_rise) begin
              rx_reg        <= rx_full;
              data_seen_reg <= 1'b1;
              boundary_reg  <= 1'b0;
              if (word_last) begin
                frame_done_reg <= 1'b1;
                bit_cnt_reg    <= '0;
                if (!rw_reg) begin
                  spi_we_reg    <= 1'b1;
                  spi_waddr_reg <= addr_reg;
                  spi_wdata_reg <= rx_full;
                end
`ifdef SPI_PERIPH_AUTOINC_EN
                // Stay in DATA for the next word; the MSB of the next
                // register is held until this word's trailing falling edge
                addr_reg      <= addr_next;
                data_seen_reg <= 1'b0;
                boundary_reg  <= 1'b1;
                if (rw_reg) begin
                  tx_reg   <= next_rd_word;
                  poci_reg <= next_rd_word[DATA_WIDTH-1];
                end
`else
                state_reg <= IGNORE;
                poci_reg  <= 1'b0;
`endif
              end else begin
                bit_cnt_reg <= bit_cnt_reg + CNT_W'(1);
              end
            end else if (sclk_fall && data_seen_reg && rw_reg) begin
              tx_reg   <= {tx_reg[DATA_WIDTH-2:0], 1'b0};
              poci_reg <= tx_reg[DATA_WIDTH-2];
            end
          end
          IGNORE: begin
            poci_reg <= 1'b0;
          end
          default: begin
            state_reg <= IDLE;
          end
        endcase
      end
    end
  end

  // Per-register write decode; an SPI write beats a host write to the same register
  logic [NUM_REGS-1:0] spi_hit;
  logic [NUM_REGS-1:0] host_hit;

  generate
    for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_hit
      assign spi_hit[gi]  = spi_we_reg && (spi_waddr_reg == ADDR_WIDTH'(gi));
      assign host_hit[gi] = host_we && (host_waddr == ADDR_WIDTH'(gi));
    end
  endgenerate

  // Register file update from the SPI side and the fabric side
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (spi_hit[i]) begin
          regs[i] <= spi_wdata_reg;
        end else if (host_hit[i]) begin
          regs[i] <= host_wdata;
        end
      end
    end
  end

  // Registered fabric-side read port, one cycle of latency
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      host_rdata_reg <= '0;
    end else begin
      host_rdata_reg <= reg_read(host_raddr);
    end
  end

  assign poci        = poci_reg;
  assign host_rdata  = host_rdata_reg;
  assign frame_done  = frame_done_reg;
  assign frame_error = frame_error_reg;
  assign addr_error  = addr_error_reg;
  assign busy        = cs_active;

endmodule
